// File: rtl/spi_slave.sv
// spi_slave: 8-bit SPI slave (CPOL=0, CPHA=0, MSB first) with a CPU register
// port. SCLK, MOSI and SS_n are oversampled in the clk domain.
module spi_slave #(
  parameter int unsigned DATABITS    = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_select,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [2:0]  mem_addr,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic        SS_n,
  output logic        MISO,
  output logic        dataavailable,
  output logic        readyfordata,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_pipe, mosi_pipe, ss_pipe;
  logic                   sclk_s, mosi_s, ss_s;
  logic                   sclk_d, ss_d;
  logic                   sclk_rise, sclk_fall, ss_fall;
  logic                   rd_d, wr_d, rd_stb, wr_stb;
  logic [DATABITS-1:0]    tx_holding, rx_holding, shift_tx, shift_rx;
  logic [3:0]             bitcnt;
  logic                   rrdy, trdy, toe, roe, tue;
  logic [15:0]            control, status;
  logic                   tx_accept;

  assign sclk_s    = sclk_pipe[SYNC_STAGES-1];
  assign mosi_s    = mosi_pipe[SYNC_STAGES-1];
  assign ss_s      = ss_pipe[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_fall   = ~ss_s & ss_d;

  assign rd_stb = spi_select & ~read_n & ~rd_d;
  assign wr_stb = spi_select & ~write_n & ~wr_d;

  assign status = {7'b0, toe | roe | tue, rrdy, trdy, trdy & (state == IDLE),
                   toe, roe, tue, 2'b0};

  // A LOAD in this cycle empties the holding register, so a same-cycle write fits
  assign tx_accept = trdy | (state == LOAD);

  assign MISO          = (!ss_s && state != IDLE) ? shift_tx[DATABITS-1] : 1'b0;
  assign dataavailable = rrdy;
  assign readyfordata  = trdy;

  // Pin synchronizers plus one-cycle history for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_pipe <= '0;
      mosi_pipe <= '0;
      ss_pipe   <= '1;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], SCLK};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], MOSI};
      ss_pipe   <= {ss_pipe[SYNC_STAGES-2:0], SS_n};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  // Access history so a held select produces a single strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_d <= 1'b0;
      wr_d <= 1'b0;
    end else begin
      rd_d <= spi_select & ~read_n;
      wr_d <= spi_select & ~write_n;
    end
  end

  // Register port and frame FSM; statement order sets same-cycle priority
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      data_to_cpu <= '0;
      tx_holding  <= '0;
      rx_holding  <= '0;
      shift_tx    <= '0;
      shift_rx    <= '0;
      bitcnt      <= '0;
      rrdy        <= 1'b0;
      trdy        <= 1'b1;
      toe         <= 1'b0;
      roe         <= 1'b0;
      tue         <= 1'b0;
      control     <= '0;
      irq         <= 1'b0;
    end else begin
      if (rd_stb) begin
        case (mem_addr)
          3'd0: begin
            data_to_cpu <= {{(16-DATABITS){1'b0}}, rx_holding};
            rrdy        <= 1'b0;
          end
          3'd2:    data_to_cpu <= status;
          3'd3:    data_to_cpu <= control;
          default: data_to_cpu <= '0;
        endcase
      end

      if (wr_stb && mem_addr == 3'd2) begin
        toe  <= 1'b0;
        roe  <= 1'b0;
        tue  <= 1'b0;
        rrdy <= 1'b0;
      end
      if (wr_stb && mem_addr == 3'd3)
        control <= data_from_cpu;

      case (state)
        IDLE: begin
          if (ss_fall)
            state <= LOAD;
        end
        LOAD: begin
          if (!trdy) begin
            shift_tx <= tx_holding;
            trdy     <= 1'b1;
          end else begin
            shift_tx <= '0;
            tue      <= 1'b1;
          end
          bitcnt <= '0;
          state  <= SHIFT;
        end
        SHIFT: begin
          if (ss_s) begin
            state <= IDLE;
          end else begin
            if (sclk_rise) begin
              shift_rx <= {shift_rx[DATABITS-2:0], mosi_s};
              bitcnt   <= bitcnt + 4'd1;
              if (bitcnt == 4'(DATABITS-1))
                state <= DONE;
            end
            // With bitcnt at 0 the falling edge is the tail of the previous
            // frame's last bit, which must not shift out the freshly loaded MSB
            if (sclk_fall && bitcnt != 4'd0)
              shift_tx <= {shift_tx[DATABITS-2:0], 1'b0};
          end
        end
        DONE: begin
          rx_holding <= shift_rx;
          if (rrdy)
            roe <= 1'b1;
          rrdy  <= 1'b1;
          state <= ss_s ? IDLE : LOAD;
        end
        default: state <= IDLE;
      endcase

      // After the FSM so a same-cycle LOAD hands over the old holding byte first
      if (wr_stb && mem_addr == 3'd1) begin
        if (tx_accept) begin
          tx_holding <= data_from_cpu[DATABITS-1:0];
          trdy       <= 1'b0;
        end else begin
          toe <= 1'b1;
        end
      end

      irq <= |(status[8:2] & control[8:2]);
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: self-checking bench for spi_slave with a transaction-level
// reference model of the register file and frame behaviour.
module tb_spi_slave;

  localparam int unsigned SYNC = 2;

  logic        clk;
  logic        reset;
  logic        spi_select;
  logic        read_n;
  logic        write_n;
  logic [2:0]  mem_addr;
  logic [15:0] data_from_cpu;
  logic [15:0] data_to_cpu;
  logic        SCLK;
  logic        MOSI;
  logic        SS_n;
  logic        MISO;
  logic        dataavailable;
  logic        readyfordata;
  logic        irq;

  spi_slave #(.DATABITS(8), .SYNC_STAGES(SYNC)) dut (
    .clk(clk),
    .reset(reset),
    .spi_select(spi_select),
    .read_n(read_n),
    .write_n(write_n),
    .mem_addr(mem_addr),
    .data_from_cpu(data_from_cpu),
    .data_to_cpu(data_to_cpu),
    .SCLK(SCLK),
    .MOSI(MOSI),
    .SS_n(SS_n),
    .MISO(MISO),
    .dataavailable(dataavailable),
    .readyfordata(readyfordata),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_tx_full, m_rrdy, m_toe, m_roe, m_tue;
  logic [7:0]  m_tx, m_rx;
  logic [15:0] m_ctrl;

  function automatic void model_reset();
    m_tx_full = 0; m_rrdy = 0; m_toe = 0; m_roe = 0; m_tue = 0;
    m_tx = '0; m_rx = '0; m_ctrl = '0;
  endfunction

  // Status as seen while no frame is in progress
  function automatic logic [15:0] model_status();
    int unsigned s;
    s = 0;
    if (m_toe || m_roe || m_tue) s += 256;
    if (m_rrdy)     s += 128;
    if (!m_tx_full) s += 64 + 32;
    if (m_toe)      s += 16;
    if (m_roe)      s += 8;
    if (m_tue)      s += 4;
    return 16'(s);
  endfunction

  function automatic logic [15:0] model_irq();
    return 16'((model_status() & m_ctrl & 16'h01FC) != 16'h0000);
  endfunction

  function automatic void model_write(input logic [2:0] a, input logic [15:0] d);
    if (a == 3'd1) begin
      if (m_tx_full) m_toe = 1;
      else begin m_tx = d[7:0]; m_tx_full = 1; end
    end else if (a == 3'd2) begin
      m_toe = 0; m_roe = 0; m_tue = 0; m_rrdy = 0;
    end else if (a == 3'd3) begin
      m_ctrl = d;
    end
  endfunction

  function automatic logic [15:0] model_read(input logic [2:0] a);
    logic [15:0] r;
    r = '0;
    if (a == 3'd0) begin r = {8'h00, m_rx}; m_rrdy = 0; end
    else if (a == 3'd2) r = model_status();
    else if (a == 3'd3) r = m_ctrl;
    return r;
  endfunction

  // A frame start (or a continuation under held SS_n) takes the pending byte
  function automatic logic [7:0] model_load();
    logic [7:0] b;
    if (m_tx_full) begin b = m_tx; m_tx_full = 0; end
    else begin b = 8'h00; m_tue = 1; end
    return b;
  endfunction

  function automatic void model_done(input logic [7:0] rx);
    if (m_rrdy) m_roe = 1;
    m_rx = rx;
    m_rrdy = 1;
  endfunction

  // ---------------- drivers ----------------
  logic [7:0] miso_cap;

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
    spi_select = 1'b1; read_n = 1'b0; mem_addr = a;
    tick(1);
    spi_select = 1'b0; read_n = 1'b1;
    d = data_to_cpu;
    tick(1);
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d, input int unsigned cycles);
    spi_select = 1'b1; write_n = 1'b0; mem_addr = a; data_from_cpu = d;
    tick(cycles);
    spi_select = 1'b0; write_n = 1'b1;
    tick(1);
  endtask

  task automatic do_write(input logic [2:0] a, input logic [15:0] d, input int unsigned cycles);
    cpu_write(a, d, cycles);
    model_write(a, d);
  endtask

  task automatic do_read(input logic [2:0] a, input string tag);
    logic [15:0] got, exp;
    exp = model_read(a);
    cpu_read(a, got);
    check(tag, got, exp);
  endtask

  task automatic ss_low();
    SS_n = 1'b0;
    tick(3);
  endtask

  task automatic ss_high();
    SS_n = 1'b1;
    MOSI = 1'b0;
    tick(8);
  endtask

  // Master clocks bits first..first+count-1 of data, capturing MISO at each rise
  task automatic clock_bits(input logic [7:0] data, input int unsigned first, input int unsigned count);
    for (int unsigned i = first; i < first + count; i++) begin
      MOSI = data[7-i];
      tick(1);
      miso_cap = {miso_cap[6:0], MISO};
      SCLK = 1'b1;
      tick(4);
      SCLK = 1'b0;
      tick(4);
    end
  endtask

  task automatic run_frame(input logic [7:0] mosi, input string tag);
    logic [7:0] exp;
    exp = model_load();
    ss_low();
    clock_bits(mosi, 0, 8);
    model_done(mosi);
    void'(model_load());
    ss_high();
    check({tag, "_miso"}, 16'(miso_cap), 16'(exp));
  endtask

  task automatic run_abort(input logic [7:0] mosi, input int unsigned k, input string tag);
    logic [7:0] exp, mask;
    exp = model_load();
    ss_low();
    clock_bits(mosi, 0, k);
    ss_high();
    mask = 8'((1 << k) - 1);
    check({tag, "_miso"}, 16'(miso_cap & mask), 16'(exp >> (8 - k)));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, checks %0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0]  got;
    logic [7:0]   e;
    int unsigned  cnt;

    reset = 1'b1; spi_select = 1'b0; read_n = 1'b1; write_n = 1'b1;
    mem_addr = '0; data_from_cpu = '0; SCLK = 1'b0; MOSI = 1'b0; SS_n = 1'b1;
    miso_cap = '0;
    model_reset();
    tick(3);
    reset = 1'b0;
    tick(1);

    // Reset state
    check("rst_dout", data_to_cpu, 16'h0000);
    check("rst_miso", 16'(MISO), 16'd0);
    check("rst_irq", 16'(irq), 16'd0);
    check("rst_rrdy", 16'(dataavailable), 16'd0);
    check("rst_trdy", 16'(readyfordata), 16'd1);
    cpu_read(3'd2, got);
    check("rst_status", got, 16'h0060);
    do_read(3'd3, "rst_ctrl");

    // Basic transfer; the long write also checks single-strobe behaviour
    do_write(3'd1, 16'h00A5, 3);
    check("basic_trdy_low", 16'(readyfordata), 16'd0);
    check("basic_no_toe", 16'(dut.status[4]), 16'd0);
    run_frame(8'h3C, "basic");
    check("basic_miso_a5", 16'(miso_cap), 16'h00A5);
    check("basic_rrdy", 16'(dataavailable), 16'd1);
    check("basic_trdy", 16'(readyfordata), 16'd1);
    cpu_read(3'd0, got);
    void'(model_read(3'd0));
    check("basic_rx", got, 16'h003C);
    check("basic_rrdy_clr", 16'(dataavailable), 16'd0);

    // Underrun then overrun
    do_write(3'd2, 16'h0000, 1);
    run_frame(8'h5A, "uo1");
    check("uo1_zero", 16'(miso_cap), 16'h0000);
    run_frame(8'hC3, "uo2");
    cpu_read(3'd2, got);
    check("uo_status", got, 16'h01EC);
    cpu_read(3'd0, got);
    void'(model_read(3'd0));
    check("uo_rx", got, 16'h00C3);
    do_write(3'd2, 16'hFFFF, 1);
    cpu_read(3'd2, got);
    check("uo_cleared", got, 16'h0060);

    // Transmit overrun
    do_write(3'd1, 16'h0011, 1);
    do_write(3'd1, 16'h0022, 1);
    cpu_read(3'd2, got);
    check("toe_status", got, 16'h0110);
    run_frame(8'h99, "toe");
    check("toe_miso_11", 16'(miso_cap), 16'h0011);

    // Abort after 5 clocks: RRDY and rx data untouched
    do_write(3'd1, 16'h004B, 1);
    run_abort(8'h66, 5, "abort");
    check("abort_rrdy", 16'(dataavailable), 16'd1);
    do_read(3'd2, "abort_status");
    run_frame(8'hE7, "abort_next");
    cpu_read(3'd0, got);
    void'(model_read(3'd0));
    check("abort_next_rx", got, 16'h00E7);

    // Back-to-back frames under one SS_n
    do_write(3'd2, 16'h0000, 1);
    do_write(3'd1, 16'h0081, 1);
    e = model_load();
    ss_low();
    clock_bits(8'h12, 0, 4);
    do_write(3'd1, 16'h007E, 1);
    clock_bits(8'h12, 4, 4);
    check("b2b_miso1", 16'(miso_cap), 16'h0081);
    model_done(8'h12);
    e = model_load();
    check("b2b_rrdy1", 16'(dataavailable), 16'd1);
    do_read(3'd0, "b2b_rx1");
    check("b2b_rrdy_clr", 16'(dataavailable), 16'd0);
    clock_bits(8'h34, 0, 8);
    check("b2b_miso2", 16'(miso_cap), 16'(e));
    model_done(8'h34);
    void'(model_load());
    check("b2b_rrdy2", 16'(dataavailable), 16'd1);
    ss_high();
    cpu_read(3'd2, got);
    check("b2b_no_roe", 16'(got[3]), 16'd0);
    do_read(3'd0, "b2b_rx2");

    // irq on RRDY, with RRDY latency measured from the 8th SCLK rise
    do_write(3'd2, 16'h0000, 1);
    do_write(3'd3, 16'h0080, 1);
    check("irq_idle", 16'(irq), 16'd0);
    e = model_load();
    ss_low();
    clock_bits(8'h5C, 0, 7);
    MOSI = 1'b0;
    tick(1);
    miso_cap = {miso_cap[6:0], MISO};
    SCLK = 1'b1;
    cnt = 0;
    while (dataavailable !== 1'b1 && cnt < 20) begin
      tick(1);
      cnt++;
    end
    check("rrdy_latency", 16'(cnt), 16'(SYNC + 2));
    check("irq_before", 16'(irq), 16'd0);
    tick(1);
    check("irq_after", 16'(irq), 16'd1);
    tick(3);
    SCLK = 1'b0;
    tick(4);
    model_done(8'h5C);
    void'(model_load());
    ss_high();
    check("irq_miso", 16'(miso_cap), 16'(e));
    do_read(3'd0, "irq_rx");
    check("irq_clear", 16'(irq), model_irq());

    // Randomized mix of register accesses and frames
    for (int it = 0; it < 60; it++) begin
      int unsigned op;
      op = $urandom_range(0, 7);
      case (op)
        0, 1: do_write(3'd1, 16'($urandom_range(0, 255)), $urandom_range(1, 3));
        2:    do_read(3'd0, "rnd_rx");
        3:    do_read(3'($urandom_range(0, 7)), "rnd_rd");
        4:    do_write(3'd2, 16'($urandom), 1);
        5:    run_frame(8'($urandom), "rnd_frame");
        6:    run_abort(8'($urandom), $urandom_range(1, 7), "rnd_abort");
        default: do_write(3'd3, 16'($urandom), 1);
      endcase
      check("rnd_rrdy", 16'(dataavailable), 16'(m_rrdy));
      check("rnd_trdy", 16'(readyfordata), 16'(!m_tx_full));
      check("rnd_irq", 16'(irq), model_irq());
    end

    // Reset asserted mid-frame
    do_write(3'd3, 16'h01FC, 1);
    do_write(3'd1, 16'h00FF, 1);
    do_read(3'd3, "pre_rst_ctrl");
    void'(model_load());
    ss_low();
    clock_bits(8'hAA, 0, 3);
    SCLK = 1'b1;
    tick(2);
    reset = 1'b1; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    tick(1);
    check("mid_rst_dout", data_to_cpu, 16'h0000);
    check("mid_rst_miso", 16'(MISO), 16'd0);
    check("mid_rst_irq", 16'(irq), 16'd0);
    check("mid_rst_rrdy", 16'(dataavailable), 16'd0);
    check("mid_rst_trdy", 16'(readyfordata), 16'd1);
    reset = 1'b0;
    model_reset();
    tick(4);
    cpu_read(3'd2, got);
    check("post_rst_status", got, 16'h0060);
    do_read(3'd3, "post_rst_ctrl");
    do_write(3'd1, 16'h003C, 1);
    run_frame(8'hC3, "post_rst");
    do_read(3'd0, "post_rst_rx");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI slave peripheral, 8-bit, CPOL=0/CPHA=0, MSB first. It is the far-end counterpart of the team's `spi_master`, for FPGA-to-FPGA links and for loopback verification of the master. SCLK, MOSI and SS_n are oversampled in the system clock domain. The CPU side is a register port with the same register map style and handshake outputs (`dataavailable`, `readyfordata`) as the master, plus an interrupt.

## Interface
- `DATABITS`, 8: frame width, fixed at 8.
- `SYNC_STAGES`, 2: synchronizer depth on SCLK, MOSI and SS_n (≥2).
- `clk` input 1: system clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `spi_select` input 1: register port chip select.
- `read_n` input 1: active-low read.
- `write_n` input 1: active-low write.
- `mem_addr` input 3: register address.
- `data_from_cpu` input 16: write data.
- `data_to_cpu` output 16: registered read data.
- `SCLK` input 1: SPI clock from master (asynchronous).
- `MOSI` input 1: master-out data.
- `SS_n` input 1: active-low slave select.
- `MISO` output 1: slave-out data; driven 0 while deselected.
- `dataavailable` output 1: equals RRDY.
- `readyfordata` output 1: equals TRDY.
- `irq` output 1: registered interrupt.

## Operation
- **Register map.**
  - 0: rxdata (r).
  - 1: txdata (w).
  - 2: status (r; any write clears TOE, ROE, TUE, RRDY).
  - 3: control (r/w; bit n enables irq for status bit n, for n = 2..8).
  - Other addresses read 0.
- **Status word.** {7'b0, E, RRDY, TRDY, TMT, TOE, ROE, TUE, 2'b0}.
  - Bit 8 = E = TOE | ROE | TUE.
  - Bit 7 = RRDY.
  - Bit 6 = TRDY = tx holding register empty.
  - Bit 5 = TMT = TRDY & no frame in progress.
- **Access strobes.** An access is one strobe per contiguous assertion of spi_select & ~read_n (or ~write_n). The strobe fires on the first cycle; later cycles are ignored.
- **txdata write.**
  - If TRDY: tx_holding ← data_from_cpu[7:0] and TRDY ← 0.
  - Otherwise: TOE ← 1 and the data is dropped.
- **rxdata read.** Returns {8'b0, rx_holding}. RRDY ← 0.
- **Synchronizer.** SCLK, MOSI and SS_n each pass through SYNC_STAGES flops. Edges are detected on the synchronized SCLK and SS_n.
- **Frame FSM states.**
  - IDLE: SS_n high, or after reset.
  - LOAD: one cycle after the synchronized SS_n falling edge.
    - If tx holding is full: shift_tx ← tx_holding and TRDY ← 1.
    - Otherwise: shift_tx ← 0x00 and TUE ← 1.
    - bitcnt ← 0. Go to SHIFT.
  - SHIFT:
    - On SCLK rising: shift_rx ← {shift_rx[6:0], MOSI_sync}, then bitcnt++.
    - On SCLK falling: shift_tx ← shift_tx << 1.
    - When bitcnt reaches 8 (8th rising edge): go to DONE.
  - DONE (one cycle):
    - rx_holding ← shift_rx.
    - If RRDY was already 1, ROE ← 1 and rx_holding is still overwritten.
    - RRDY ← 1.
    - If SS_n is still low, go to LOAD (back-to-back frames under one SS_n). Otherwise go to IDLE.
- **Output.** MISO = shift_tx[7] while SS_n_sync is low and the FSM is not IDLE; otherwise 0.
- **SS_n rising mid-frame (bitcnt < 8).**
  - Return to IDLE.
  - Discard the partial byte. RRDY, rx_holding and flags are unchanged.
  - Any tx byte already moved into shift_tx is lost; TRDY stays 1.
- **Simultaneous events.**
  - CPU txdata write in the same cycle as LOAD: LOAD takes the old holding content, then the write fills holding; no TOE.
  - rxdata read in the same cycle as DONE: the read returns the old rx_holding, and RRDY ends at 1.
  - Status write in the same cycle as a flag set: the set wins.
- **irq.** irq ← |(status[8:2] & control[8:2]), registered.

## Timing
- **Reset values.**
  - data_to_cpu = 0, MISO = 0, irq = 0.
  - RRDY = 0, TRDY = 1, all error flags 0, control = 0.
  - FSM in IDLE.
  - dataavailable = 0, readyfordata = 1.
- **Read latency.** data_to_cpu is valid 1 clk after the read strobe cycle.
- **Write latency.** The write takes effect at the end of the strobe cycle. TRDY falls the next cycle.
- **Input latency.** SCLK, MOSI and SS_n are seen SYNC_STAGES+1 clk after the pin changes.
- **SCLK limit.** SCLK high and low phases must each be ≥ 4 clk periods. This matches the master with SPI_FRE_DIV ≥ 2.
- **MISO update.** MISO changes ≤ SYNC_STAGES+2 clk after the SCLK falling pin edge.
- **First bit.** MISO's first bit is valid ≤ SYNC_STAGES+2 clk after SS_n falls. The master must allow ≥ 4 clk from SS_n low to the first SCLK rise.
- **RRDY timing.** RRDY rises SYNC_STAGES+2 clk after the 8th SCLK rising pin edge.

## Test plan
- **Basic transfer.** Preload txdata 0xA5; master sends 0x3C at 4-clk half period.
  - MISO bits are 1,0,1,0,0,1,0,1.
  - rxdata reads 0x003C; RRDY = 1, then 0 after the read.
  - TRDY = 1 after LOAD.
- **Underrun and overrun.** Run two frames with no txdata write and no rxdata read.
  - MISO is all zeros and TUE = 1.
  - After frame 2: ROE = 1 and rxdata is the second byte.
  - A status write clears TUE, ROE and RRDY.
- **TOE.** Write txdata 0x11, then 0x22 before any frame.
  - TOE = 1.
  - The next frame transmits 0x11.
- **Abort.** SS_n rises after 5 SCLK edges.
  - RRDY is unchanged, FSM returns to IDLE.
  - The next full frame receives correctly.
- **Back-to-back frames.** SS_n held low for 2 frames, tx 0x81 then 0x7E written in between.
  - Both bytes appear on MISO.
  - RRDY is set twice, with no ROE when rxdata is read in between.
- **irq and reset.** With control bit 7 set, irq rises 1 clk after RRDY. Reset asserted mid-frame returns every output to its reset value on the next clk.
